// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the mod_counter block.
package mod_counter_pkg;

  localparam int unsigned COUNTER_WIDTH_DEFAULT = 5;

  typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage

// File: rtl/mod_counter_if.sv
// Count output bus of mod_counter; master drives, slave observes.
interface mod_counter_if
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] c;

  modport master (output c);
  modport slave  (input  c);

endinterface

// File: rtl/mod_counter_next.sv
// Combinational next-count logic: wraps to zero after the terminal value.
module mod_counter_next #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_next,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  always_comb begin
    tc     = (c == MaxVal);
    c_next = tc ? '0 : c + WIDTH'(1);
  end

endmodule

// File: rtl/mod_counter.sv
// Free-running modulo-(MAX_COUNT+1) up-counter with registered output and async clear.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = COUNTER_WIDTH_DEFAULT,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
  input logic            clk,
  input logic            rst,
  mod_counter_if.master  cnt
);

  if (MAX_COUNT < 1 || MAX_COUNT > (1 << WIDTH) - 1) begin : g_bad_max
    $error("mod_counter: MAX_COUNT out of range for WIDTH");
  end

  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] c_d;
  logic             unused_tc;

  mod_counter_next #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_next (
    .c      (c_q),
    .c_next (c_d),
    .tc     (unused_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign cnt.c = c_q;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: default (5-bit, wrap at 31) and WIDTH=4/MAX_COUNT=9 instances.
module tb_mod_counter;
  import mod_counter_pkg::*;

  logic clk;
  logic rst;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: edges counted since the last reset release; count is that modulo the period.
  int unsigned edges;

  mod_counter_if #(.WIDTH(COUNTER_WIDTH_DEFAULT)) bus_a ();
  mod_counter_if #(.WIDTH(4))                     bus_b ();

  mod_counter #(
    .WIDTH     (COUNTER_WIDTH_DEFAULT),
    .MAX_COUNT (31)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .cnt (bus_a)
  );

  mod_counter #(
    .WIDTH     (4),
    .MAX_COUNT (9)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .cnt (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_xfree(input string name);
    n_checks++;
    if ($isunknown(bus_a.c) || $isunknown(bus_b.c)) begin
      n_fail++;
      $display("FAIL %s at %0t: got a=%b b=%b, expected known values", name, $time,
               bus_a.c, bus_b.c);
    end
  endtask

  // Per-cycle compare against the model, sampled 1 ns after each falling edge.
  initial begin
    @(negedge clk);
    forever begin
      #1;
      check_xfree("known");
      check("model_a", int'(bus_a.c), int'(edges % 32));
      check("model_b", int'(bus_b.c), int'(edges % 10));
      check("range_b", int'(bus_b.c <= 4'd9), 1);
      @(negedge clk);
    end
  end

  initial begin
    count_t a_val;
    rst = 1'b1;
    #5;
    a_val = bus_a.c;
    check("por_a_t5", int'(a_val), 0);
    check("por_b_t5", int'(bus_b.c), 0);
    #30;                                   // t=35, edges at 10 and 30 passed
    check("por_a_t35", int'(bus_a.c), 0);
    check("por_b_t35", int'(bus_b.c), 0);
    #5 rst = 1'b0;                         // t=40
    #15;                                   // t=55
    check("rel_a_1", int'(bus_a.c), 1);
    check("rel_b_1", int'(bus_b.c), 1);
    #580;                                  // t=635, after 30 edges
    check("cnt_a_30", int'(bus_a.c), 30);
    check("cnt_b_30", int'(bus_b.c), 0);
    #5 rst = 1'b1;                         // t=640, between edges
    #1;
    check("async_a", int'(bus_a.c), 0);
    check("async_b", int'(bus_b.c), 0);
    #34;                                   // t=675, edges 650 and 670 passed
    check("hold_a", int'(bus_a.c), 0);
    check("hold_b", int'(bus_b.c), 0);
    #5 rst = 1'b0;                         // t=680
    #15;                                   // t=695
    check("restart_a", int'(bus_a.c), 1);
    check("restart_b", int'(bus_b.c), 1);
    #600;                                  // t=1295, after 31 edges
    check("cnt_a_31", int'(bus_a.c), 31);
    check("cnt_b_31", int'(bus_b.c), 1);
    #20;                                   // t=1315
    check("wrap_a", int'(bus_a.c), 0);
    check("wrap_b", int'(bus_b.c), 2);
    #20;                                   // t=1335
    check("post_wrap_a", int'(bus_a.c), 1);
    check("post_wrap_b", int'(bus_b.c), 3);
    #700;                                  // several more wraps under the per-cycle compare
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
